// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared defaults and FSM encoding for the programmable sequence detector
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CNT_W   = 8;

  // Reset config reproduces the fixed 10101 overlapping detector
  localparam logic [7:0] DEF_RST_PATTERN = 8'b0001_0101;
  localparam int         DEF_RST_LEN     = 5;
  localparam logic       DEF_RST_OVERLAP = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_ARMED = 2'd2
  } state_e;

endpackage

// File: rtl/seq_match_cmp.sv
// rtl/seq_match_cmp.sv - masked compare of shift history against the programmed pattern
module seq_match_cmp
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);

  logic [MAX_LEN-1:0] mask;

  // Only the newest len bits take part; older history is ignored
  always_comb begin
    mask = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      mask[k] = (k < int'(len));
    end
    match = (((hist ^ pattern) & mask) == '0);
  end

endmodule

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable Moore sequence detector with saturating match counter
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = DEF_MAX_LEN,
  parameter int                 LEN_W       = DEF_LEN_W,
  parameter int                 CNT_W       = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
  parameter int                 RST_LEN     = DEF_RST_LEN,
  parameter logic               RST_OVERLAP = DEF_RST_OVERLAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i,
  input  logic               in_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_RST   = LEN_W'(RST_LEN);
  localparam state_e           STATE_RST = (RST_LEN == 0) ? S_IDLE : S_FILL;

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  state_e             state_q, state_d;

  logic [MAX_LEN-1:0] new_hist;
  logic [LEN_W:0]     fill_inc;
  logic               cmp_match;
  logic               accept;
  logic               window_done;
  logic               hit;

  assign new_hist = {hist_q[MAX_LEN-2:0], i};

  seq_match_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist    (new_hist),
    .pattern (pattern_q),
    .len     (len_q),
    .match   (cmp_match)
  );

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;

    fill_inc    = {1'b0, fill_q} + (LEN_W+1)'(1);
    accept      = in_valid && !cfg_we;
    window_done = (state_q == S_ARMED) || (fill_inc >= {1'b0, len_q});
    hit         = accept && (state_q != S_IDLE) && window_done && cmp_match;

    // A config write restarts the window and swallows the same-cycle bit
    if (cfg_we) begin
      pattern_d = cfg_pattern;
      len_d     = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      overlap_d = cfg_overlap;
      fill_d    = '0;
    end else if (in_valid) begin
      hist_d = new_hist;
      if (hit && !overlap_q) begin
        fill_d = '0;
      end else if (fill_q < len_q) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end

    out_d = hit;

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (len_d == '0) begin
      state_d = S_IDLE;
    end else if (fill_d == len_d) begin
      state_d = S_ARMED;
    end else begin
      state_d = S_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= RST_PATTERN;
      len_q     <= LEN_RST;
      overlap_q <= RST_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      out_q     <= 1'b0;
      cnt_q     <= '0;
      state_q   <= STATE_RST;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - directed self-checking bench for seq_detect_prog
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i = 1'b0;
  logic       in_valid = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       out, out2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_detect_prog dut (
    .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .out(out), .match_cnt(match_cnt)
  );

  seq_detect_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .out(out2), .match_cnt(match_cnt2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic b, input logic exp_out, input string tag);
    i = b; in_valid = 1'b1;
    tick();
    chk(tag, int'(out), int'(exp_out));
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0;
    tick();
    chk(tag, int'(out), 0);
  endtask

  // Config write with a live valid bit=1 so a non-discarded bit would shift the stream
  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                     input logic clr);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
    cnt_clr = clr; i = 1'b1; in_valid = 1'b1;
    tick();
    cfg_we = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
    chk("cfg_out", int'(out), 0);
  endtask

  initial begin
    // 1: reset defaults, overlapping 10101
    do_reset();
    chk("rst_out", int'(out), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    send(1, 0, "t1_b1"); send(0, 0, "t1_b2"); send(1, 0, "t1_b3");
    send(0, 0, "t1_b4"); send(1, 1, "t1_b5"); send(0, 0, "t1_b6");
    send(1, 1, "t1_b7");
    chk("t1_cnt", int'(match_cnt), 2);

    // 2: 110, len 3, non-overlapping; counter cleared with the config write
    cfg(8'b0000_0110, 4'd3, 1'b0, 1'b1);
    chk("t2_clr", int'(match_cnt), 0);
    send(1, 0, "t2_b1"); send(1, 0, "t2_b2"); send(0, 1, "t2_b3");
    send(1, 0, "t2_b4"); send(1, 0, "t2_b5"); send(0, 1, "t2_b6");
    send(1, 0, "t2_b7"); send(0, 0, "t2_b8");
    chk("t2_cnt", int'(match_cnt), 2);

    // 3: back to default, invalid gap does not break the sequence
    cfg(8'b0001_0101, 4'd5, 1'b1, 1'b0);
    chk("t3_cnt_hold", int'(match_cnt), 2);
    send(1, 0, "t3_b1"); send(0, 0, "t3_b2"); send(1, 0, "t3_b3"); send(0, 0, "t3_b4");
    idle("t3_gap1"); idle("t3_gap2"); idle("t3_gap3");
    send(1, 1, "t3_b5");
    chk("t3_cnt", int'(match_cnt), 3);

    // 4: len 0 disables; len 12 clamps to 8
    cfg(8'b0001_0101, 4'd0, 1'b1, 1'b0);
    send(1, 0, "t4_z1"); send(0, 0, "t4_z2"); send(1, 0, "t4_z3");
    send(0, 0, "t4_z4"); send(1, 0, "t4_z5");
    chk("t4_zcnt", int'(match_cnt), 3);
    cfg(8'hFF, 4'd12, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) send(1, 0, $sformatf("t4_one%0d", k));
    send(1, 1, "t4_one8");
    send(1, 1, "t4_one9");
    chk("t4_cnt", int'(match_cnt), 5);

    // 5: 2-bit counter saturates; cnt_clr beats a coincident match
    do_reset();
    chk("t5_rst_cnt2", int'(match_cnt2), 0);
    for (int k = 0; k < 11; k++) begin
      send(((k % 2) == 0) ? 1'b1 : 1'b0, (k >= 4 && (k % 2) == 0) ? 1'b1 : 1'b0,
           $sformatf("t5_b%0d", k + 1));
    end
    chk("t5_cnt2_sat", int'(match_cnt2), 3);
    chk("t5_cnt8", int'(match_cnt), 4);
    send(0, 0, "t5_b12");
    cnt_clr = 1'b1;
    send(1, 1, "t5_b13");
    cnt_clr = 1'b0;
    chk("t5_clr_cnt8", int'(match_cnt), 0);
    chk("t5_clr_cnt2", int'(match_cnt2), 0);

    // 6: reset mid-pattern drops partial history
    do_reset();
    send(1, 0, "t6_a1"); send(0, 0, "t6_a2"); send(1, 0, "t6_a3"); send(0, 0, "t6_a4");
    do_reset();
    chk("t6_rst_out", int'(out), 0);
    chk("t6_rst_cnt", int'(match_cnt), 0);
    send(1, 0, "t6_b1"); send(0, 0, "t6_b2"); send(1, 0, "t6_b3");
    send(0, 0, "t6_b4"); send(1, 1, "t6_b5");
    chk("t6_cnt", int'(match_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
